// File: rtl/somador_completo_8b_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives the operands and the slave (the adder) drives the registered result.
interface somador_completo_8b_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;
  logic             Zero;
  logic             out_valid;

  modport master (
    output in_valid, A, B, CIN,
    input  S, Cout, Ovf, Zero, out_valid
  );

  modport slave (
    input  in_valid, A, B, CIN,
    output S, Cout, Ovf, Zero, out_valid
  );
endinterface

// File: rtl/somador_completo_8b.sv
// Registered N-bit ripple-carry adder built from per-bit full-adder cells.
// Sum, carry-out, signed overflow and zero flag are registered once when in_valid is high.
module somador_completo_8b #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  somador_completo_8b_if.slave bus
);

  logic [WIDTH-1:0] s_next;
  logic             c_msb_in;
  logic             c_msb_out;

  // Each cell keeps its own carry-in/carry-out so the chain is not one self-referencing vector.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic ci;
      logic co;
      logic p;

      if (gi == 0) begin : g_first
        assign ci = bus.CIN;
      end else begin : g_chain
        assign ci = g_cell[gi-1].co;
      end

      assign p          = bus.A[gi] ^ bus.B[gi];
      assign s_next[gi] = p ^ ci;
      assign co         = (bus.A[gi] & bus.B[gi]) | (ci & p);
    end
  endgenerate

  assign c_msb_in  = g_cell[WIDTH-1].ci;
  assign c_msb_out = g_cell[WIDTH-1].co;

  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic             out_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s_reg    <= s_next;
        cout_reg <= c_msb_out;
        ovf_reg  <= c_msb_out ^ c_msb_in;
        zero_reg <= ~|s_next;
      end
    end
  end

  assign bus.S         = s_reg;
  assign bus.Cout      = cout_reg;
  assign bus.Ovf       = ovf_reg;
  assign bus.Zero      = zero_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_somador_completo_8b.sv
// Directed and randomized checks of the registered adder against an arithmetic model.
module tb_somador_completo_8b;

  logic clk = 1'b0;
  logic rst_n;

  somador_completo_8b_if #(.WIDTH(8)) bus ();

  somador_completo_8b #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_s;
  logic       exp_c;
  logic       exp_o;
  logic       exp_z;
  logic       exp_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".S"},         32'(bus.S),         32'(exp_s));
    chk({tag, ".Cout"},      32'(bus.Cout),      32'(exp_c));
    chk({tag, ".Ovf"},       32'(bus.Ovf),       32'(exp_o));
    chk({tag, ".Zero"},      32'(bus.Zero),      32'(exp_z));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_v));
  endtask

  task automatic model_clear();
    exp_s = 8'h00; exp_c = 1'b0; exp_o = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
  endtask

  // Plain 9-bit arithmetic; signed overflow from operand/result sign bits.
  task automatic model_add(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] t;
    t     = {1'b0, a} + {1'b0, b} + {8'h00, ci};
    exp_s = t[7:0];
    exp_c = t[8];
    exp_o = (a[7] == b[7]) && (t[7] != a[7]);
    exp_z = (t[7:0] == 8'h00);
    exp_v = 1'b1;
  endtask

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input string tag, input bit verbose);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.CIN      = ci;
    @(posedge clk);
    #1;
    if (v) model_add(a, b, ci);
    else   exp_v = 1'b0;
    check_all(tag);
    if (verbose)
      $display("%s: v=%0b A=%02h B=%02h CIN=%0b -> S=%02h Cout=%0b Ovf=%0b Zero=%0b out_valid=%0b",
               tag, v, a, b, ci, bus.S, bus.Cout, bus.Ovf, bus.Zero, bus.out_valid);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.A        = 8'h00;
    bus.B        = 8'h00;
    bus.CIN      = 1'b0;
    model_clear();

    // Reset held while inputs toggle: outputs stay cleared across edges.
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'($urandom);
      bus.A        = 8'($urandom);
      bus.B        = 8'($urandom);
      bus.CIN      = 1'($urandom);
      #7;
      check_all("reset_hold");
    end
    $display("reset_hold: outputs cleared while rst_n=0");

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_v = bus.in_valid ? 1'b1 : 1'b0;
    if (bus.in_valid) model_add(bus.A, bus.B, bus.CIN);
    check_all("release");

    step(1'b1, 8'h00, 8'h00, 1'b0, "zero_sum",  1'b1);
    step(1'b1, 8'hFF, 8'h00, 1'b0, "ff_plus_0", 1'b1);
    step(1'b1, 8'hFF, 8'h01, 1'b0, "ff_plus_1", 1'b1);
    step(1'b1, 8'hFF, 8'h10, 1'b0, "ff_plus_10", 1'b1);
    step(1'b1, 8'h7F, 8'h01, 1'b0, "signed_ovf", 1'b1);
    step(1'b1, 8'hFF, 8'hFF, 1'b1, "ff_ff_cin", 1'b1);
    step(1'b1, 8'h80, 8'h80, 1'b0, "neg_ovf",   1'b1);

    // Back-to-back results, then holds with fresh garbage on the operand lines.
    step(1'b1, 8'h12, 8'h34, 1'b0, "b2b_0", 1'b1);
    step(1'b1, 8'h56, 8'h78, 1'b1, "b2b_1", 1'b1);
    step(1'b1, 8'h9A, 8'hBC, 1'b0, "b2b_2", 1'b1);
    step(1'b0, 8'h01, 8'h02, 1'b1, "hold_0", 1'b1);
    step(1'b0, 8'hFE, 8'hFD, 1'b0, "hold_1", 1'b1);

    // Reset between edges with a valid operand pending.
    step(1'b1, 8'h40, 8'h41, 1'b0, "pre_reset", 1'b1);
    bus.in_valid = 1'b1;
    bus.A        = 8'hAA;
    bus.B        = 8'h55;
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all("mid_reset_async");
    @(posedge clk);
    #1;
    check_all("mid_reset_edge");
    $display("mid_reset: outputs cleared before next edge");
    #2;
    rst_n = 1'b1;
    step(1'b1, 8'h01, 8'h01, 1'b1, "post_reset", 1'b1);

    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
           "random", 1'b0);
    end
    $display("random: 10000 steps compared against arithmetic model");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
